int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//  Interrupt controller on the other side of the control unit's interrupt interface.
//  - Synchronises and latches external requests; the latched requests are the pending set.
//  - Presents the highest-priority pending request (min_bit_s) and in-service request (min_bit_a),
//    both one-hot, to the control unit.
//  - Consumes the control unit's s_calli (enter) and s_reti (exit) one-hot strobes.
//  - Bit 0 is highest priority; bit 0 is also the ALU-overflow interrupt.
// PARAMETERS
//  N_IRQ        8   number of interrupt lines; fixed by the CU interface width, do not change
//  SYNC_STAGES  2   flip-flop stages on each irq line (>=2)
//  EDGE_MODE    1   1: rising edge on the synchronised irq sets pending; 0: level sets pending each cycle
// PORTS
//  clk         in   1  system clock; everything rises on posedge
//  reset       in   1  synchronous, active-low reset
//  irq         in   8  asynchronous external request lines; irq[0] also usable as overflow source
//  irq_en      in   8  per-line enable; gates presentation only, pending still latches
//  s_calli     in   8  one-hot interrupt entry strobe from CU, valid for one cycle
//  s_reti      in   8  one-hot interrupt return strobe from CU, valid for one cycle
//  min_bit_s   out  8  one-hot lowest set bit of (pending & irq_en); 0 if none
//  min_bit_a   out  8  one-hot lowest set bit of in_service; 0 if none
//  pending_o   out  8  raw pending register (debug/status)
//  overrun_o   out  8  sticky: an edge arrived while that line was already pending
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - sync chain, pending, in_service and overrun go to 0.
//   - As a result, min_bit_s, min_bit_a, pending_o and overrun_o read 0 in the next cycle.
//   - Reset asserted mid-service discards all nesting state; a later s_reti is a no-op.
//  Synchroniser / event
//   - irq passes through SYNC_STAGES flops, giving irq_s.
//   - EDGE_MODE=1: new_ev = irq_s & ~irq_s_q, where irq_s_q is irq_s delayed one cycle.
//   - EDGE_MODE=0: new_ev = irq_s.
//   - Latency from an irq edge to the pending bit is SYNC_STAGES+1 cycles; min_bit_s shows it in the same cycle.
//  pending
//   - Update: pending <= (pending & ~s_calli) | new_ev.
//   - If a new event and s_calli hit the same bit in the same cycle, the bit stays set (the new event is not lost).
//  overrun
//   - Set: overrun[i] <= 1 when new_ev[i] & pending[i] & ~s_calli[i].
//   - Clear: cleared only by reset.
//  in_service
//   - Update: in_service <= (in_service & ~s_reti) | s_calli.
//   - If s_calli and s_reti arrive in the same cycle, the clear applies first and the set second.
//   - s_reti on a bit that is not in service: no-op.
//   - s_calli with multiple bits set: each bit is handled independently.
//   - s_calli on a bit that is not pending (e.g. overflow forces bit 0): in_service still sets and pending is unaffected.
//   - Nesting: several in_service bits may be set at once; min_bit_a always reports the lowest.
//  Outputs
//   - min_bit_s, min_bit_a are combinational from registers only.
//   - They have no combinational path from s_calli/s_reti, so there is no loop through the CU.
//  Preemption
//   - The controller does not decide preemption; the CU compares min_bit_s against min_bit_a.
//   - The controller's contract is only correct, stable registered state.
// STRUCTURE
//  - Shared include int_defs.vh holds: N_IRQ=8, OVF_BIT=0, the CU field positions for s_calli [30:23]
//    and s_reti [22:15]. The CU uses the same include.
//  - Sub-module lsb_onehot (8-bit in, 8-bit one-hot out, 0 if input is 0): x & (~x + 1).
//    Instantiated twice, for min_bit_s and min_bit_a.
//  - Synchroniser, edge detect and pending/in_service/overrun registers live inline in int_ctrl.
// TESTING
//  1 Reset:
//    - hold reset=0 for 2 clk with irq=8'hFF -> all outputs 8'h00.
//    - Release -> pending_o=8'hFF after SYNC_STAGES+1 cycles.
//  2 Priority:
//    - irq=8'b0010_1000, irq_en=8'hFF -> min_bit_s=8'b0000_1000.
//    - Then irq_en=8'hF7 -> min_bit_s=8'b0010_0000.
//  3 Call/return:
//    - pending 8'h08, pulse s_calli=8'h08 for 1 cycle -> pending_o=0, min_bit_a=8'h08.
//    - Pulse s_reti=8'h08 -> min_bit_a=0.
//  4 Nesting:
//    - in_service 8'h20, then s_calli=8'h04 -> min_bit_a=8'h04.
//    - s_reti=8'h04 -> min_bit_a=8'h20.
//    - s_reti=8'h80 (not in service) -> no change.
//  5 Same-cycle collision:
//    - irq[3] edge timed so new_ev[3] coincides with s_calli=8'h08 -> pending_o[3] stays 1, overrun_o=0.
//    - A second edge while still pending -> overrun_o[3]=1.
//  6 Overflow path:
//    - s_calli=8'h01 with pending=0 -> min_bit_a=8'h01, pending_o unchanged.
//    - Assert reset mid-service -> min_bit_a=0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared interrupt-controller definitions: line count, overflow bit and the
// positions of the entry/return strobe fields inside the CU control word.
package int_ctrl_pkg;
  localparam int N_IRQ     = 8;
  localparam int OVF_BIT   = 0;
  localparam int CALLI_MSB = 30;
  localparam int CALLI_LSB = 23;
  localparam int RETI_MSB  = 22;
  localparam int RETI_LSB  = 15;

  typedef logic [N_IRQ-1:0] irq_vec_t;
endpackage

// File: rtl/int_ctrl_lsb_onehot.sv
// Isolates the lowest set bit of a vector as a one-hot value (0 when input is 0).
module lsb_onehot
  import int_ctrl_pkg::*;
(
  input  irq_vec_t x_i,
  output irq_vec_t y_o
);
  assign y_o = x_i & (~x_i + irq_vec_t'(1));
endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises external requests, tracks pending, in-service
// and overrun state, and presents the highest-priority pending/active lines to the CU.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  irq_vec_t irq,
  input  irq_vec_t irq_en,
  input  irq_vec_t s_calli,
  input  irq_vec_t s_reti,
  output irq_vec_t min_bit_s,
  output irq_vec_t min_bit_a,
  output irq_vec_t pending_o,
  output irq_vec_t overrun_o
);
  irq_vec_t sync_q [SYNC_STAGES];
  irq_vec_t irq_s, irq_s_q, new_ev;
  irq_vec_t pending_q, pending_d;
  irq_vec_t in_service_q, in_service_d;
  irq_vec_t overrun_q, overrun_d;
  irq_vec_t pres_s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      irq_s_q <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      irq_s_q <= irq_s;
    end
  end

  assign irq_s  = sync_q[SYNC_STAGES-1];
  assign new_ev = (EDGE_MODE != 0) ? (irq_s & ~irq_s_q) : irq_s;

  // A new event on a bit being entered this cycle survives the clear.
  always_comb begin
    pending_d    = (pending_q & ~s_calli) | new_ev;
    in_service_d = (in_service_q & ~s_reti) | s_calli;
    overrun_d    = overrun_q | (new_ev & pending_q & ~s_calli);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      overrun_q    <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      overrun_q    <= overrun_d;
    end
  end

  // Outputs depend on registers only, so no loop forms through the CU strobes.
  assign pres_s = pending_q & irq_en;

  lsb_onehot u_min_s (.x_i(pres_s),       .y_o(min_bit_s));
  lsb_onehot u_min_a (.x_i(in_service_q), .y_o(min_bit_a));

  assign pending_o = pending_q;
  assign overrun_o = overrun_q;
endmodule
